// File: rtl/act_unpacker.sv
// Unpacks 8/4/2-bit packed activation words into one sign-extended byte per lane,
// emitting 1, 2 or 4 beats per accepted word with valid/ready on both sides.
module act_unpacker #(
  parameter int         N_DIM_ARRAY    = 16,
  parameter int         ACT_DATA_WIDTH = 8,
  parameter logic [2:0] MODE_CNN       = 3'd1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear,
  input  logic [1:0]                          PRECISION,
  input  logic [2:0]                          mode,
  input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
);

  localparam int AW = ACT_DATA_WIDTH;
  localparam int W  = N_DIM_ARRAY * ACT_DATA_WIDTH;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t       state_r;
  state_t       state_nxt_s;
  logic [W-1:0] word_r;
  logic [W-1:0] out_data_r;
  logic [1:0]   prec_r;
  logic         cnn_r;
  logic [1:0]   beat_r;
  logic [1:0]   prec_in_s;
  logic [1:0]   last_beat_s;
  logic         last_s;
  logic         accept_s;
  logic         advance_s;

  // Precision code 3 behaves as 8b, so it is folded to 0 before latching.
  assign prec_in_s   = (PRECISION == 2'd3) ? 2'd0 : PRECISION;
  assign last_beat_s = (prec_r == 2'd1) ? 2'd1 : ((prec_r == 2'd2) ? 2'd3 : 2'd0);
  assign last_s      = (beat_r == last_beat_s);
  assign accept_s    = in_valid && in_ready;
  assign advance_s   = (state_r == EMIT) && out_ready;
  assign out_data    = out_data_r;

  // CNN: lane e keeps its own lane, field k. FC/EWS: beat k spans a slice of
  // lanes, each packed lane fanning out to consecutive output elements.
  function automatic logic [W-1:0] decode(input logic [W-1:0] w, input logic [1:0] p,
                                          input logic cnn, input logic [1:0] k);
    logic [W-1:0] r;
    logic [3:0]   nib;
    logic [1:0]   crumb;
    int           lane;
    int           sel;
    r = w;
    for (int e = 0; e < N_DIM_ARRAY; e++) begin
      case (p)
        2'd1: begin
          lane = cnn ? e : int'(k[0]) * (N_DIM_ARRAY / 2) + e / 2;
          sel  = cnn ? int'(k[0]) : e % 2;
          nib  = w[lane*AW + 4*sel +: 4];
          r[e*AW +: AW] = {{(AW-4){nib[3]}}, nib};
        end
        2'd2: begin
          lane  = cnn ? e : int'(k) * (N_DIM_ARRAY / 4) + e / 4;
          sel   = cnn ? int'(k) : e % 4;
          crumb = w[lane*AW + 2*sel +: 2];
          r[e*AW +: AW] = {{(AW-2){crumb[1]}}, crumb};
        end
        default: r[e*AW +: AW] = w[e*AW +: AW];
      endcase
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; clear wins over accept and advance.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = accept_s ? EMIT : IDLE;
        EMIT:    state_nxt_s = (advance_s && last_s && !accept_s) ? IDLE : EMIT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      IDLE: in_ready = !reset && !clear;
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        in_ready  = !clear && last_s && out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Word hold, beat counter and registered beat data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_r     <= '0;
      out_data_r <= '0;
      prec_r     <= 2'd0;
      cnn_r      <= 1'b0;
      beat_r     <= 2'd0;
    end else if (clear) begin
      beat_r     <= 2'd0;
      out_data_r <= '0;
    end else if (accept_s) begin
      word_r     <= in_data;
      prec_r     <= prec_in_s;
      cnn_r      <= (mode == MODE_CNN);
      beat_r     <= 2'd0;
      out_data_r <= decode(in_data, prec_in_s, (mode == MODE_CNN), 2'd0);
    end else if (advance_s && !last_s) begin
      beat_r     <= beat_r + 2'd1;
      out_data_r <= decode(word_r, prec_r, cnn_r, beat_r + 2'd1);
    end else if (advance_s) begin
      beat_r     <= 2'd0;
    end
  end

endmodule

// File: doc/act_unpacker.md
Name: act_unpacker

Overview:
- Converts packed sub-byte activation words, in the layout the PE array output stage produces, back into one 8-bit sign-extended activation per lane.
- Feeds the input buffer's serial/parallel inputs on the next layer.
- Inverse of the array's 8/4/2-bit output packing for both CNN and FC/EWS modes.
- Valid/ready handshakes on both sides; one word register and a beat sequencer.

Parameters:
- N_DIM_ARRAY, 16, number of lanes; must be a multiple of 4.
- ACT_DATA_WIDTH, 8, bits per lane, packed and unpacked.
- MODE_CNN, 3'd1, mode encoding that selects the CNN (per-lane) layout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush: drops the held word, returns to IDLE
- PRECISION  in  2  0=8b, 1=4b, 2=2b, 3=treated as 8b; sampled at word accept
- mode  in  3  MODE_CNN selects the per-lane layout; any other value selects the FC/EWS layout; sampled at word accept
- in_data  in  N_DIM_ARRAY*ACT_DATA_WIDTH  packed word; lane m = bits [8m+7:8m]
- in_valid  in  1  in_data valid
- in_ready  out  1  unpacker can accept a word this cycle
- out_data  out  N_DIM_ARRAY*ACT_DATA_WIDTH  unpacked activations, lane m = element m
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data this cycle
- busy  out  1  a word is held (state EMIT)

Behaviour:
- Reset values: out_valid=0, busy=0, out_data=0, beat counter=0, state IDLE. in_ready=1 once reset is released.
- Beats per word, B: 1 (8b), 2 (4b), 4 (2b).
- Accept: occurs when in_valid && in_ready. The word, PRECISION and mode are latched and state goes to EMIT. Beat 0 is presented the following cycle (latency 1).
- in_ready = IDLE || (EMIT && last beat && out_ready). Back-to-back words therefore stream at full throughput with no bubble.
- In EMIT: out_valid=1 and out_data = current beat. On out_ready the beat counter increments. On the last beat, the state returns to IDLE, unless a new word is accepted in the same cycle; then the counter resets to 0 and the state stays EMIT.
- out_data is stable while out_valid && !out_ready.
- Beat decode, CNN layout. Lane m output for beat k is field k of packed lane m, sign-extended to 8 bits:
  - 4b: beat 0 = bits[3:0], beat 1 = bits[7:4].
  - 2b: beat k = bits[2k+1:2k], k=0..3.
- Beat decode, FC/EWS layout, 4b. Beat k uses packed lanes k*N/2 .. k*N/2+N/2-1. Output element 2j comes from nibble [3:0] of packed lane k*N/2+j; element 2j+1 comes from nibble [7:4].
- Beat decode, FC/EWS layout, 2b. Beat k uses packed lanes k*N/4 .. k*N/4+N/4-1. Output element 4j+q comes from bits [2q+1:2q] of packed lane k*N/4+j.
- 8b: out_data = latched word unchanged, in both modes.
- Sign extension: always arithmetic (MSB of the field replicated).
- clear has priority over accept and over advance. The same cycle as clear: out_valid=0 next cycle, state IDLE, counter 0, and any in_valid word offered that cycle is not accepted (in_ready forced 0 while clear=1).
- PRECISION or mode changing while busy has no effect until the next accept.
- reset asserted mid-word: all state returns to reset values immediately (asynchronous); the held word is lost.

Test Plan:
- Reset then 8b, mode CNN, in_data lanes = m+1, out_ready=1 -> out_valid one cycle after accept; lane m = m+1; in_ready stays 1; busy pulses one cycle per word.
- 4b CNN, every lane 8'hA3, out_ready=1 -> beat0 all lanes 8'h03, beat1 all lanes 8'hFA (-6); in_ready low during beat0 and high during beat1.
- 2b FC with N=16, lane 0 = 8'b11_10_01_00, other lanes 0 -> beat0 elements 0..3 = 0, 1, -2, -1; beats 1-3 all zero; 4 out beats, then IDLE.
- 4b FC, word W1 then W2 back-to-back, out_ready toggling 1,0,1,1,0,1 -> no lost or duplicated beats; out_data held stable on stalls; 4 beats total in order W1b0, W1b1, W2b0, W2b1.
- 2b CNN, clear asserted during beat 2 with in_valid=1 -> next cycle out_valid=0, busy=0; offered word not accepted; following word decodes from beat 0.
- Reset asserted mid-beat in 4b -> out_valid, busy and out_data go to 0 immediately; after release a fresh 8b word passes with 1-cycle latency.
